fetch_pc_stage: RTL and testbench

Instruction-fetch stage that owns the program counter, drives the instruction-memory request, and loads the IF/ID pipeline register. It takes the 2-bit next-PC select and jump target from the decode-stage address-select logic, plus the branch-correction target. It produces the IF/ID instruction and PC that address-select decodes. It handles stalls through a one-entry hold buffer and squashes wrong-path fetches on redirect.

---
 rtl/fetch_pc_stage_if.sv | 11 +
 rtl/fetch_pc_stage.sv | 135 +++++++++++++
 tb/tb_fetch_pc_stage.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_pc_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests and
// loads the IF/ID register, with a one-entry hold buffer and wrong-path squash.
module fetch_pc_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             pcsrc,
  input  logic [31:0]            j_addr,
  input  logic [31:0]            redirect_addr,
  input  logic                   stall,
  fetch_pc_stage_if.master       imem,
  output logic [31:0]            pc,
  output logic [31:0]            ifid_instr,
  output logic [31:0]            ifid_pc,
  output logic                   ifid_valid
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] ifid_instr_nxt, ifid_pc_nxt;
  logic        ifid_valid_nxt;
  logic [31:0] buf_instr, buf_instr_nxt;
  logic [31:0] buf_pc, buf_pc_nxt;
  logic [31:0] discard_addr, discard_addr_nxt;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;

  // pcsrc=11 is neither jump nor correction and falls through as sequential.
  assign redirect = (pcsrc == 2'b01) || (pcsrc == 2'b10);
  assign target   = ((pcsrc == 2'b01) ? j_addr : redirect_addr) & 32'hFFFF_FFFC;
  assign pc_inc   = pc + 32'd4;

  // NOTE: every output of this block gets a default first so that no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    ifid_instr_nxt   = ifid_instr;
    ifid_pc_nxt      = ifid_pc;
    ifid_valid_nxt   = ifid_valid;
    buf_instr_nxt    = buf_instr;
    buf_pc_nxt       = buf_pc;
    discard_addr_nxt = discard_addr;
    imem.imem_req    = 1'b0;
    imem.imem_addr   = pc;

    unique case (state)
      BOOT: begin
        state_nxt = FETCH;
        if (redirect) pc_nxt = target;
      end

      FETCH: begin
        imem.imem_req = 1'b1;
        if (redirect) begin
          pc_nxt         = target;
          ifid_instr_nxt = NOP;
          ifid_valid_nxt = 1'b0;
          if (!imem.imem_ready) begin
            // The in-flight request must complete at its original address.
            discard_addr_nxt = pc;
            state_nxt        = DISCARD;
          end
        end else if (imem.imem_ready && !stall) begin
          ifid_instr_nxt = imem.imem_rdata;
          ifid_pc_nxt    = pc;
          ifid_valid_nxt = 1'b1;
          pc_nxt         = pc_inc;
        end else if (imem.imem_ready) begin
          buf_instr_nxt = imem.imem_rdata;
          buf_pc_nxt    = pc;
          state_nxt     = HOLD;
        end else if (!stall) begin
          ifid_instr_nxt = NOP;
          ifid_valid_nxt = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_nxt         = target;
          ifid_instr_nxt = NOP;
          ifid_valid_nxt = 1'b0;
          state_nxt      = FETCH;
        end else if (!stall) begin
          ifid_instr_nxt = buf_instr;
          ifid_pc_nxt    = buf_pc;
          ifid_valid_nxt = 1'b1;
          pc_nxt         = pc_inc;
          state_nxt      = FETCH;
        end
      end

      DISCARD: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = discard_addr;
        if (redirect) pc_nxt = target;
        if (imem.imem_ready) state_nxt = FETCH;
      end

      default: state_nxt = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      ifid_instr   <= NOP;
      ifid_pc      <= 32'h0;
      ifid_valid   <= 1'b0;
      buf_instr    <= NOP;
      buf_pc       <= 32'h0;
      discard_addr <= RESET_PC;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      ifid_instr   <= ifid_instr_nxt;
      ifid_pc      <= ifid_pc_nxt;
      ifid_valid   <= ifid_valid_nxt;
      buf_instr    <= buf_instr_nxt;
      buf_pc       <= buf_pc_nxt;
      discard_addr <= discard_addr_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Self-checking bench for fetch_pc_stage: directed scenarios plus randomized
// traffic compared against a flag-based behavioural model of the fetch rules.
module tb_fetch_pc_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pcsrc;
  logic [31:0] j_addr, redirect_addr;
  logic        stall;
  logic [31:0] pc, ifid_instr, ifid_pc;
  logic        ifid_valid;

  fetch_pc_stage_if imem();

  fetch_pc_stage dut (
    .clk(clk), .rst_n(rst_n), .pcsrc(pcsrc), .j_addr(j_addr),
    .redirect_addr(redirect_addr), .stall(stall), .imem(imem),
    .pc(pc), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what the pipeline should hold, tracked as plain flags.
  logic [31:0] m_pc, m_instr, m_ipc, m_hb_instr, m_hb_pc, m_disc_addr;
  logic        m_valid, m_boot, m_held, m_disc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic m_req();
    return !m_boot && !m_held;
  endfunction

  function automatic logic [31:0] m_addr();
    return m_disc ? m_disc_addr : m_pc;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_valid = 1'b0;
    m_boot = 1'b1; m_held = 1'b0; m_disc = 1'b0;
    m_hb_instr = NOP; m_hb_pc = 32'h0; m_disc_addr = 32'h0;
  endtask

  task automatic model_step(input logic [1:0] src, input logic [31:0] ja, ra,
                            input logic st, rdy, input logic [31:0] rd);
    logic        redir;
    logic [31:0] tgt;
    redir = (src == 2'd1) || (src == 2'd2);
    tgt   = ((src == 2'd1) ? ja : ra) & 32'hFFFF_FFFC;
    if (m_boot) begin
      m_boot = 1'b0;
      if (redir) m_pc = tgt;
    end else if (m_held) begin
      if (redir) begin
        m_held = 1'b0; m_pc = tgt; m_instr = NOP; m_valid = 1'b0;
      end else if (!st) begin
        m_held = 1'b0; m_instr = m_hb_instr; m_ipc = m_hb_pc; m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else if (m_disc) begin
      if (redir) m_pc = tgt;
      if (rdy) m_disc = 1'b0;
    end else begin
      if (redir) begin
        if (!rdy) begin m_disc = 1'b1; m_disc_addr = m_pc; end
        m_pc = tgt; m_instr = NOP; m_valid = 1'b0;
      end else if (rdy && !st) begin
        m_instr = rd; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end else if (rdy) begin
        m_held = 1'b1; m_hb_instr = rd; m_hb_pc = m_pc;
      end else if (!st) begin
        m_valid = 1'b0; m_instr = NOP;
      end
    end
  endtask

  // Apply one cycle of inputs from the falling edge, clock it, land on the next falling edge.
  task automatic cyc(input logic [1:0] src, input logic [31:0] ja, ra,
                     input logic st, rdy);
    logic [31:0] rd;
    rd = rdy ? mem_word(m_addr()) : $urandom;
    pcsrc = src; j_addr = ja; redirect_addr = ra; stall = st;
    imem.imem_ready = rdy; imem.imem_rdata = rd;
    @(posedge clk);
    model_step(src, ja, ra, st, rdy, rd);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pcsrc = 2'b00; j_addr = '0; redirect_addr = '0; stall = 1'b0;
    imem.imem_ready = 1'b0; imem.imem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (imem.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %0b want 0", imem.imem_req); end
    n_cmp++; if (imem.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", imem.imem_addr); end
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", pc); end
    n_cmp++; if (ifid_instr !== NOP) begin n_err++; $display("FAIL reset_instr got %h want %h", ifid_instr, NOP); end
    n_cmp++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0) begin n_err++; $display("FAIL reset_ifid got v=%0b pc=%h want v=0 pc=0", ifid_valid, ifid_pc); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    cyc(2'b00, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'(4 * i)) begin
        n_err++; $display("FAIL seq_addr got req=%0b addr=%h want req=1 addr=%h", imem.imem_req, imem.imem_addr, 32'(4 * i)); end
      cyc(2'b00, '0, '0, 1'b0, 1'b1);
      n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'(4 * i) || ifid_instr !== mem_word(32'(4 * i))) begin
        n_err++; $display("FAIL seq_ifid got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                          ifid_valid, ifid_pc, ifid_instr, 32'(4 * i), mem_word(32'(4 * i))); end
    end
  endtask

  task automatic test_jump();
    n_cmp++; if (pc !== 32'h10) begin n_err++; $display("FAIL jump_start_pc got %h want 10", pc); end
    cyc(2'b01, 32'h103, '0, 1'b0, 1'b1);
    n_cmp++; if (imem.imem_addr !== 32'h100) begin n_err++; $display("FAIL jump_addr got %h want 100", imem.imem_addr); end
    n_cmp++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin n_err++; $display("FAIL jump_squash got v=%0b instr=%h want v=0 instr=%h", ifid_valid, ifid_instr, NOP); end
    cyc(2'b00, '0, '0, 1'b0, 1'b1);
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100) begin n_err++; $display("FAIL jump_next got v=%0b pc=%h want v=1 pc=100", ifid_valid, ifid_pc); end
  endtask

  task automatic test_discard();
    cyc(2'b10, '0, 32'h200, 1'b0, 1'b0);
    n_cmp++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h104) begin n_err++; $display("FAIL disc_hold1 got req=%0b addr=%h want req=1 addr=104", imem.imem_req, imem.imem_addr); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL disc_squash got v=%0b want 0", ifid_valid); end
    cyc(2'b00, '0, '0, 1'b0, 1'b0);
    n_cmp++; if (imem.imem_addr !== 32'h104) begin n_err++; $display("FAIL disc_hold2 got %h want 104", imem.imem_addr); end
    cyc(2'b00, '0, '0, 1'b0, 1'b1);
    n_cmp++; if (imem.imem_addr !== 32'h200 || ifid_valid !== 1'b0) begin n_err++; $display("FAIL disc_done got addr=%h v=%0b want addr=200 v=0", imem.imem_addr, ifid_valid); end
  endtask

  task automatic test_stall();
    cyc(2'b01, 32'h1C, '0, 1'b0, 1'b1);
    cyc(2'b00, '0, '0, 1'b0, 1'b1);
    n_cmp++; if (pc !== 32'h20) begin n_err++; $display("FAIL stall_start_pc got %h want 20", pc); end
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, '0, '0, 1'b1, (i == 0));
      n_cmp++; if (imem.imem_req !== 1'b0 || ifid_pc !== 32'h1C || ifid_instr !== mem_word(32'h1C) || pc !== 32'h20) begin
        n_err++; $display("FAIL stall_freeze%0d got req=%0b ifid_pc=%h instr=%h pc=%h want req=0 ifid_pc=1c instr=%h pc=20",
                          i, imem.imem_req, ifid_pc, ifid_instr, pc, mem_word(32'h1C)); end
    end
    cyc(2'b00, '0, '0, 1'b0, 1'b0);
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h20 || ifid_instr !== mem_word(32'h20)) begin
      n_err++; $display("FAIL stall_release got v=%0b pc=%h instr=%h want v=1 pc=20 instr=%h", ifid_valid, ifid_pc, ifid_instr, mem_word(32'h20)); end
    n_cmp++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h24) begin n_err++; $display("FAIL stall_resume got req=%0b addr=%h want req=1 addr=24", imem.imem_req, imem.imem_addr); end
  endtask

  task automatic test_hold_redirect();
    cyc(2'b00, '0, '0, 1'b1, 1'b1);
    n_cmp++; if (imem.imem_req !== 1'b0) begin n_err++; $display("FAIL holdj_enter got req=%0b want 0", imem.imem_req); end
    cyc(2'b01, 32'h40, '0, 1'b1, 1'b0);
    n_cmp++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin n_err++; $display("FAIL holdj_squash got v=%0b instr=%h want v=0 instr=%h", ifid_valid, ifid_instr, NOP); end
    n_cmp++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h40) begin n_err++; $display("FAIL holdj_addr got req=%0b addr=%h want req=1 addr=40", imem.imem_req, imem.imem_addr); end
    cyc(2'b00, '0, '0, 1'b0, 1'b1);
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h40) begin n_err++; $display("FAIL holdj_next got v=%0b pc=%h want v=1 pc=40", ifid_valid, ifid_pc); end
  endtask

  task automatic test_wrap();
    cyc(2'b10, '0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    n_cmp++; if (imem.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_target got %h want fffffffc", imem.imem_addr); end
    cyc(2'b11, 32'h500, 32'h600, 1'b0, 1'b1);
    n_cmp++; if (pc !== 32'h0 || imem.imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_pc got pc=%h addr=%h want 0", pc, imem.imem_addr); end
    n_cmp++; if (ifid_pc !== 32'hFFFF_FFFC || ifid_valid !== 1'b1) begin n_err++; $display("FAIL wrap_ifid got pc=%h v=%0b want fffffffc v=1", ifid_pc, ifid_valid); end
  endtask

  task automatic test_random();
    logic [1:0]  src;
    logic [31:0] ja, ra;
    logic        st, rdy;
    int          r;
    for (int n = 0; n < 600; n++) begin
      r   = $urandom_range(0, 99);
      src = (r < 10) ? 2'b01 : (r < 20) ? 2'b10 : (r < 25) ? 2'b11 : 2'b00;
      ja  = $urandom;
      ra  = $urandom;
      st  = ($urandom_range(0, 99) < 25);
      rdy = ($urandom_range(0, 99) < 70);
      cyc(src, ja, ra, st, rdy);
      n_cmp++; if (imem.imem_req !== m_req()) begin n_err++; $display("FAIL rnd_req cyc %0d got %0b want %0b", n, imem.imem_req, m_req()); end
      n_cmp++; if (m_req() && imem.imem_addr !== m_addr()) begin n_err++; $display("FAIL rnd_addr cyc %0d got %h want %h", n, imem.imem_addr, m_addr()); end
      n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL rnd_pc cyc %0d got %h want %h", n, pc, m_pc); end
      n_cmp++; if (ifid_valid !== m_valid || ifid_instr !== m_instr) begin
        n_err++; $display("FAIL rnd_ifid cyc %0d got v=%0b instr=%h want v=%0b instr=%h", n, ifid_valid, ifid_instr, m_valid, m_instr); end
      n_cmp++; if (m_valid && ifid_pc !== m_ipc) begin n_err++; $display("FAIL rnd_ifid_pc cyc %0d got %h want %h", n, ifid_pc, m_ipc); end
    end
  endtask

  task automatic test_async_reset();
    cyc(2'b10, '0, 32'h300, 1'b0, 1'b1);
    cyc(2'b10, '0, 32'h300, 1'b0, 1'b1);
    cyc(2'b00, '0, '0, 1'b0, 1'b1);
    imem.imem_ready = 1'b0;
    #2;
    n_cmp++; if (imem.imem_req !== 1'b1) begin n_err++; $display("FAIL arst_pre_req got %0b want 1", imem.imem_req); end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (imem.imem_req !== 1'b0 || imem.imem_addr !== 32'h0 || pc !== 32'h0) begin
      n_err++; $display("FAIL arst_bus got req=%0b addr=%h pc=%h want 0", imem.imem_req, imem.imem_addr, pc); end
    n_cmp++; if (ifid_instr !== NOP || ifid_valid !== 1'b0 || ifid_pc !== 32'h0) begin
      n_err++; $display("FAIL arst_ifid got instr=%h v=%0b pc=%h want %h 0 0", ifid_instr, ifid_valid, ifid_pc, NOP); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2'b00, '0, '0, 1'b0, 1'b1);
    n_cmp++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
      n_err++; $display("FAIL arst_first_req got req=%0b addr=%h want req=1 addr=0", imem.imem_req, imem.imem_addr); end
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_discard();
    test_stall();
    test_hold_redirect();
    test_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
